// File: rtl/q_edge_counter.sv
// q_edge_counter: counts rising and falling transitions of q over a window of window_len samples
module q_edge_counter #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             sat
);
  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t           state_q, state_d;
  logic [WIN_W-1:0] rem_q, rem_d;
  logic             q_prev_q, q_prev_d;
  logic [CNT_W-1:0] rise_q, rise_d, fall_q, fall_d;
  logic             sat_q, sat_d, busy_q, busy_d, done_q, done_d;
  logic             rise_ev, fall_ev;
  assign rise_ev = !q_prev_q && q;
  assign fall_ev = q_prev_q && !q;
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    q_prev_d = q_prev_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    sat_d    = sat_q;
    unique case (state_q)
      IDLE: if (start) begin
        rise_d   = '0;
        fall_d   = '0;
        sat_d    = 1'b0;
        rem_d    = window_len;
        q_prev_d = (window_len != '0) ? q : q_prev_q;
        state_d  = (window_len != '0) ? MEASURE : DONE;
      end
      MEASURE: begin
        // an increment attempted at the ceiling raises sat instead of wrapping
        rise_d   = (rise_ev && rise_q != CNT_MAX) ? rise_q + 1'b1 : rise_q;
        fall_d   = (fall_ev && fall_q != CNT_MAX) ? fall_q + 1'b1 : fall_q;
        sat_d    = sat_q || (rise_ev && rise_q == CNT_MAX) || (fall_ev && fall_q == CNT_MAX);
        q_prev_d = q;
        rem_d    = rem_q - 1'b1;
        state_d  = (rem_q == WIN_W'(1)) ? DONE : MEASURE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MEASURE);
    done_d = (state_d == DONE);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      q_prev_q <= 1'b0;
      rise_q   <= '0;
      fall_q   <= '0;
      sat_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      q_prev_q <= q_prev_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sat_q    <= sat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign rise_cnt = rise_q;
  assign fall_cnt = fall_q;
  assign sat      = sat_q;
endmodule

// File: tb/tb_q_edge_counter.sv
// tb_q_edge_counter: random windows on a 16-bit and a 3-bit counter instance against a sample-list model
module tb_q_edge_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic q = 1'b0;
  logic start = 1'b0;
  logic [15:0] window_len = '0;
  logic busy16, done16, sat16, busy3, done3, sat3;
  logic [15:0] rise16, fall16;
  logic [2:0] rise3, fall3;
  logic [34:0] act16;
  logic [8:0] act3;
  int vecs = 0;
  int miss = 0;
  always #5 clk = ~clk;
  q_edge_counter dut16 (
    .clk(clk), .rst(rst), .q(q), .start(start), .window_len(window_len),
    .busy(busy16), .done(done16), .rise_cnt(rise16), .fall_cnt(fall16), .sat(sat16)
  );
  q_edge_counter #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .q(q), .start(start), .window_len(window_len),
    .busy(busy3), .done(done3), .rise_cnt(rise3), .fall_cnt(fall3), .sat(sat3)
  );
  assign act16 = {busy16, done16, rise16, fall16, sat16};
  assign act3  = {busy3, done3, rise3, fall3, sat3};
  function automatic logic [34:0] mk16(input bit b, input bit d, input int r, input int f);
    return {b, d, 16'(r > 65535 ? 65535 : r), 16'(f > 65535 ? 65535 : f), (r > 65535) || (f > 65535)};
  endfunction
  function automatic logic [8:0] mk3(input bit b, input bit d, input int r, input int f);
    return {b, d, 3'(r > 7 ? 7 : r), 3'(f > 7 ? 7 : f), (r > 7) || (f > 7)};
  endfunction
  function automatic logic next_q(input int mode, input logic cur);
    case (mode)
      0:       return ~cur;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return ($urandom_range(0, 3) == 0) ? ~cur : cur;
    endcase
  endfunction
  // One window: start at the current negedge, E0 on the following posedge.
  // mode: 0 toggle, 1 constant high, 2 random, 3 sparse toggles.
  task automatic do_window(input string tag, input int len, input int mode, input bit mid, input bit hold);
    int r = 0;
    int f = 0;
    logic prev;
    logic [34:0] e16;
    logic [8:0] e3;
    start = 1'b1;
    window_len = 16'(len);
    q = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    prev = q;
    @(negedge clk);
    start = hold;
    for (int i = 1; i <= len; i++) begin
      e16 = mk16(1'b1, 1'b0, r, f);
      e3  = mk3(1'b1, 1'b0, r, f);
      vecs += 2;
      if (act16 !== e16) begin miss++; $display("FAIL %s measure16 s%0d got=%h exp=%h", tag, i, act16, e16); end
      if (act3 !== e3) begin miss++; $display("FAIL %s measure3 s%0d got=%h exp=%h", tag, i, act3, e3); end
      q = next_q(mode, q);
      if (q && !prev) r++;
      if (!q && prev) f++;
      prev = q;
      if (mid) begin
        start = 1'($urandom_range(0, 1));
        window_len = 16'($urandom_range(1, 50));
      end
      @(negedge clk);
    end
    e16 = mk16(1'b0, 1'b1, r, f);
    e3  = mk3(1'b0, 1'b1, r, f);
    vecs += 2;
    if (act16 !== e16) begin miss++; $display("FAIL %s done16 got=%h exp=%h", tag, act16, e16); end
    if (act3 !== e3) begin miss++; $display("FAIL %s done3 got=%h exp=%h", tag, act3, e3); end
    start = hold;
    q = 1'($urandom_range(0, 1));
    @(negedge clk);
    e16 = mk16(1'b0, 1'b0, r, f);
    e3  = mk3(1'b0, 1'b0, r, f);
    vecs += 2;
    if (act16 !== e16) begin miss++; $display("FAIL %s hold16 got=%h exp=%h", tag, act16, e16); end
    if (act3 !== e3) begin miss++; $display("FAIL %s hold3 got=%h exp=%h", tag, act3, e3); end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    window_len = 16'd5;
    repeat (3) @(negedge clk);
    vecs += 2;
    if (act16 !== 35'd0) begin miss++; $display("FAIL reset16 got=%h exp=0", act16); end
    if (act3 !== 9'd0) begin miss++; $display("FAIL reset3 got=%h exp=0", act3); end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_basic();
    do_window("toggle8", 8, 0, 1'b0, 1'b0);
    do_window("const20", 20, 1, 1'b0, 1'b0);
    do_window("len0", 0, 2, 1'b0, 1'b0);
  endtask
  task automatic test_saturate();
    do_window("sat20", 20, 0, 1'b0, 1'b0);
    do_window("sat_clear", 4, 0, 1'b0, 1'b0);
  endtask
  task automatic test_mid_start();
    do_window("mid_start", 12, 2, 1'b1, 1'b0);
  endtask
  task automatic test_back_to_back();
    do_window("b2b_a", 6, 0, 1'b0, 1'b1);
    do_window("b2b_b", 3, 2, 1'b0, 1'b1);
    do_window("b2b_c", 0, 2, 1'b0, 1'b0);
  endtask
  task automatic test_reset_mid();
    start = 1'b1;
    window_len = 16'd10;
    q = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      q = ~q;
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    vecs += 2;
    if (act16 !== 35'd0) begin miss++; $display("FAIL rst_mid16 got=%h exp=0", act16); end
    if (act3 !== 9'd0) begin miss++; $display("FAIL rst_mid3 got=%h exp=0", act3); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vecs += 2;
      if (act16 !== 35'd0) begin miss++; $display("FAIL rst_idle16 got=%h exp=0", act16); end
      if (act3 !== 9'd0) begin miss++; $display("FAIL rst_idle3 got=%h exp=0", act3); end
    end
    do_window("after_rst", 10, 0, 1'b0, 1'b0);
  endtask
  task automatic test_random();
    for (int k = 0; k < 30; k++)
      do_window("random", $urandom_range(0, 40), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    start = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_mid_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/q_edge_counter.md
Q_EDGE_COUNTER -- requirements
Module: q_edge_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of edge counters.
REQ-002 SHALL have parameter WIN_W, default 16: width of measurement window length.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port q, input, 1: toggle flip-flop output under observation, synchronous to clk.
REQ-006 SHALL have port start, input, 1: measurement request, level-sampled.
REQ-007 SHALL have port window_len, input, WIN_W: number of q samples to measure, captured with start.
REQ-008 SHALL have port busy, output, 1: high while a measurement is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rise_cnt, output, CNT_W: count of 0->1 transitions of q in last window.
REQ-011 SHALL have port fall_cnt, output, CNT_W: count of 1->0 transitions of q in last window.
REQ-012 SHALL have port sat, output, 1: sticky flag, either counter saturated in current/last window.

Function
REQ-013 SHALL implement FSM states IDLE, MEASURE, DONE; all outputs registered.
REQ-014 IDLE: start=1 at edge E0 with window_len!=0 -> MEASURE; clear rise_cnt, fall_cnt, sat; load remaining=window_len; q_prev<=q.
REQ-015 IDLE: start=1 with window_len==0 -> DONE directly; counters and sat cleared; no q sampled.
REQ-016 MEASURE: at each edge E1..EN (N=window_len) compare q to q_prev; q_prev=0,q=1 -> rise_cnt+1; q_prev=1,q=0 -> fall_cnt+1; then q_prev<=q, remaining-1.
REQ-017 MEASURE: at EN (remaining==1) -> DONE; exactly N samples counted, no more, no fewer.
REQ-018 DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-019 busy SHALL be 1 in MEASURE only; done 1 in DONE only; never both high.
REQ-020 start SHALL be ignored in MEASURE and DONE; window_len changes after E0 SHALL not affect the active window.
REQ-021 Counters SHALL saturate at 2^CNT_W-1 (no wrap); an increment attempted at max sets sat=1.
REQ-022 sat SHALL remain 1 until next accepted start.
REQ-023 rise_cnt, fall_cnt, sat SHALL hold their final values from DONE until next accepted start.
REQ-024 |rise_cnt - fall_cnt| SHALL be <= 1 whenever sat=0.
REQ-025 Back-to-back: start held high continuously SHALL launch a new window at the first edge in IDLE after DONE.

Reset
REQ-026 rst=0 SHALL asynchronously force state IDLE, busy=0, done=0, rise_cnt=0, fall_cnt=0, sat=0, q_prev=0, remaining=0.
REQ-027 Reset asserted mid-MEASURE SHALL abort the window with no done pulse; after release block waits in IDLE for start.
REQ-028 After rst deasserts, first start SHALL be accepted no earlier than the first posedge with rst=1.

Verification
REQ-029 q toggling every cycle, start with window_len=8 -> busy 8 cycles, done one cycle after E8, rise_cnt=4, fall_cnt=4, sat=0.
REQ-030 q held constant 1, window_len=20 -> rise_cnt=0, fall_cnt=0, done after 20 busy cycles.
REQ-031 window_len=0 -> no busy cycle, done on cycle after start, counts 0.
REQ-032 CNT_W=3, q toggling every cycle, window_len=20 -> rise_cnt=7, fall_cnt=7, sat=1; sat cleared by next start.
REQ-033 rst pulled low at sample 5 of window_len=10 -> all outputs 0 immediately, no done; new start after release completes normally.
REQ-034 start re-asserted during MEASURE and with new window_len -> ignored; window length and counts unchanged.
